udi_spect_accum: RTL and testbench

- Downstream stage of the UDI spectral-density datapath.
- Consumes the per-bin power word (I²+Q² sum / sum-shift result) produced by the spectral-density stage.
- Integrates the power over a programmable frame of bins and tracks the peak bin and its index.
- At frame end, presents the frame sum, peak value and peak index to the UDI result mux with a one-cycle valid pulse.

---
 rtl/udi_spect_accum.sv | 182 ++++++++++++++++++
 tb/tb_udi_spect_accum.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/udi_spect_accum.sv
// udi_spect_accum
// ----------------------------------------------------------------------------
// Frame integrator for the UDI spectral-density datapath. It sums per-bin
// power words over a programmable frame of (length code + 1) bins, saturating
// at all-ones. It also tracks the peak bin value and the index of that bin.
// When a frame completes, it presents the result with a one-cycle valid pulse.
//
// Ports
//   gclk            clock, all state on rising edge
//   greset          asynchronous active-high reset
//   in_pwr          unsigned power sample (32 bits)
//   in_valid        in_pwr valid this cycle
//   in_len          frame-length code (frame = in_len + 1 bins)
//   udi_ctl_len_wr  load in_len into the pending length register
//   udi_ctl_clr     synchronous abort of the current frame
//   out_sum         saturated sum of the last completed frame
//   out_peak        maximum power of the last completed frame
//   out_peak_idx    bin index of out_peak (earliest bin on ties)
//   out_valid       one-cycle pulse when the out_* result registers update
//   out_busy        frame in progress (FSM in ACCUM); also the FSM state view
//   out_frames      completed-frame counter, wraps
//
// Handshake: a sample is consumed on every rising edge where in_valid=1 and
// udi_ctl_clr=0. There is no backpressure, so one sample can be taken per
// cycle. out_valid is asserted for exactly one cycle, in the cycle after the
// last bin of a frame is consumed. ACC_W must be greater than 32.
module udi_spect_accum #(
  parameter int LEN_W = 10,
  parameter int ACC_W = 42,
  parameter int CNT_W = 16
) (
  input  logic             gclk,
  input  logic             greset,
  input  logic [31:0]      in_pwr,
  input  logic             in_valid,
  input  logic [LEN_W-1:0] in_len,
  input  logic             udi_ctl_len_wr,
  input  logic             udi_ctl_clr,
  output logic [ACC_W-1:0] out_sum,
  output logic [31:0]      out_peak,
  output logic [LEN_W-1:0] out_peak_idx,
  output logic             out_valid,
  output logic             out_busy,
  output logic [CNT_W-1:0] out_frames
);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [31:0]      peak_q, peak_d;
  logic [LEN_W-1:0] pidx_q, pidx_d;
  logic [LEN_W-1:0] bin_q, bin_d;
  logic [LEN_W-1:0] pend_len_q, pend_len_d;
  logic [LEN_W-1:0] act_len_q, act_len_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [31:0]      opeak_q, opeak_d;
  logic [LEN_W-1:0] oidx_q, oidx_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] frames_q, frames_d;

  // Per-sample datapath
  logic             accept;
  logic             starting;
  logic [LEN_W-1:0] frame_len;
  logic [LEN_W-1:0] cur_bin;
  logic [ACC_W-1:0] pwr_ext;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_new;
  logic             take_peak;
  logic [31:0]      peak_new;
  logic [LEN_W-1:0] idx_new;
  logic             last_bin;

  always_comb begin
    accept    = in_valid && !udi_ctl_clr;   // clr drops a coincident sample
    starting  = (state_q == S_IDLE);
    // When a frame starts in IDLE, it uses the pending length. The pending
    // value is the one held before any write in this same cycle.
    frame_len = starting ? pend_len_q : act_len_q;
    cur_bin   = starting ? '0 : bin_q;
    pwr_ext   = ACC_W'(in_pwr);
    sum_wide  = {1'b0, acc_q} + {1'b0, pwr_ext};
    if (starting)
      acc_new = pwr_ext;
    else if (sum_wide[ACC_W])
      acc_new = '1;                         // saturate on carry-out
    else
      acc_new = sum_wide[ACC_W-1:0];
    // Strict compare keeps the earliest index on ties; bin 0 always seeds.
    take_peak = starting || (in_pwr > peak_q);
    peak_new  = take_peak ? in_pwr : peak_q;
    idx_new   = take_peak ? cur_bin : pidx_q;
    last_bin  = accept && (cur_bin == frame_len);
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    peak_d     = peak_q;
    pidx_d     = pidx_q;
    bin_d      = bin_q;
    pend_len_d = pend_len_q;
    act_len_d  = act_len_q;
    sum_d      = sum_q;
    opeak_d    = opeak_q;
    oidx_d     = oidx_q;
    valid_d    = 1'b0;
    frames_d   = frames_q;

    if (udi_ctl_len_wr)
      pend_len_d = in_len;

    if (udi_ctl_clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      peak_d  = '0;
      pidx_d  = '0;
      bin_d   = '0;
    end else if (accept) begin
      if (starting)
        act_len_d = pend_len_q;
      if (last_bin) begin
        // Return to IDLE at once so the next cycle's sample is bin 0.
        state_d  = S_IDLE;
        acc_d    = '0;
        peak_d   = '0;
        pidx_d   = '0;
        bin_d    = '0;
        sum_d    = acc_new;
        opeak_d  = peak_new;
        oidx_d   = idx_new;
        valid_d  = 1'b1;
        frames_d = frames_q + 1'b1;
      end else begin
        state_d = S_ACCUM;
        acc_d   = acc_new;
        peak_d  = peak_new;
        pidx_d  = idx_new;
        bin_d   = cur_bin + 1'b1;
      end
    end
  end

  always_ff @(posedge gclk or posedge greset) begin
    if (greset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      peak_q     <= '0;
      pidx_q     <= '0;
      bin_q      <= '0;
      pend_len_q <= '1;
      act_len_q  <= '1;
      sum_q      <= '0;
      opeak_q    <= '0;
      oidx_q     <= '0;
      valid_q    <= 1'b0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      peak_q     <= peak_d;
      pidx_q     <= pidx_d;
      bin_q      <= bin_d;
      pend_len_q <= pend_len_d;
      act_len_q  <= act_len_d;
      sum_q      <= sum_d;
      opeak_q    <= opeak_d;
      oidx_q     <= oidx_d;
      valid_q    <= valid_d;
      frames_q   <= frames_d;
    end
  end

  assign out_sum      = sum_q;
  assign out_peak     = opeak_q;
  assign out_peak_idx = oidx_q;
  assign out_valid    = valid_q;
  assign out_busy     = (state_q == S_ACCUM);
  assign out_frames   = frames_q;

endmodule

// File: tb/tb_udi_spect_accum.sv
// Directed testbench for udi_spect_accum. Two instances share all inputs:
// dut uses the default ACC_W=42, and dut_s uses ACC_W=33 so that its
// saturation point can be reached with four full-scale samples.
// Inputs are driven on the falling edge, and outputs are checked on the
// following falling edge.
module tb_udi_spect_accum;

  localparam int LEN_W = 10;
  localparam int CNT_W = 16;

  logic             gclk;
  logic             greset;
  logic [31:0]      in_pwr;
  logic             in_valid;
  logic [LEN_W-1:0] in_len;
  logic             udi_ctl_len_wr;
  logic             udi_ctl_clr;

  logic [41:0]      out_sum;
  logic [31:0]      out_peak;
  logic [LEN_W-1:0] out_peak_idx;
  logic             out_valid;
  logic             out_busy;
  logic [CNT_W-1:0] out_frames;

  logic [32:0]      s_sum;
  logic [31:0]      s_peak;
  logic [LEN_W-1:0] s_peak_idx;
  logic             s_valid;
  logic             s_busy;
  logic [CNT_W-1:0] s_frames;

  int checks;
  int failures;

  udi_spect_accum #(.LEN_W(LEN_W), .ACC_W(42), .CNT_W(CNT_W)) dut (
    .gclk(gclk), .greset(greset), .in_pwr(in_pwr), .in_valid(in_valid),
    .in_len(in_len), .udi_ctl_len_wr(udi_ctl_len_wr), .udi_ctl_clr(udi_ctl_clr),
    .out_sum(out_sum), .out_peak(out_peak), .out_peak_idx(out_peak_idx),
    .out_valid(out_valid), .out_busy(out_busy), .out_frames(out_frames)
  );

  udi_spect_accum #(.LEN_W(LEN_W), .ACC_W(33), .CNT_W(CNT_W)) dut_s (
    .gclk(gclk), .greset(greset), .in_pwr(in_pwr), .in_valid(in_valid),
    .in_len(in_len), .udi_ctl_len_wr(udi_ctl_len_wr), .udi_ctl_clr(udi_ctl_clr),
    .out_sum(s_sum), .out_peak(s_peak), .out_peak_idx(s_peak_idx),
    .out_valid(s_valid), .out_busy(s_busy), .out_frames(s_frames)
  );

  // clock
  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at a falling edge, then return at the next
  // falling edge, so that registered outputs reflect this cycle's inputs.
  task automatic drive(input logic v, input logic [31:0] p, input logic wr,
                       input logic [LEN_W-1:0] ln, input logic clr);
    in_valid       = v;
    in_pwr         = p;
    udi_ctl_len_wr = wr;
    in_len         = ln;
    udi_ctl_clr    = clr;
    @(negedge gclk);
  endtask

  task automatic sample(input logic [31:0] p);
    drive(1'b1, p, 1'b0, '0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, '0, 1'b0);
  endtask

  task automatic set_len(input logic [LEN_W-1:0] ln);
    drive(1'b0, 32'd0, 1'b1, ln, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    greset         = 1'b1;
    in_pwr         = '0;
    in_valid       = 1'b0;
    in_len         = '0;
    udi_ctl_len_wr = 1'b0;
    udi_ctl_clr    = 1'b0;
    @(negedge gclk);
    @(negedge gclk);

    // reset state
    chk("rst_sum",    64'(out_sum),      64'd0);
    chk("rst_peak",   64'(out_peak),     64'd0);
    chk("rst_idx",    64'(out_peak_idx), 64'd0);
    chk("rst_valid",  64'(out_valid),    64'd0);
    chk("rst_busy",   64'(out_busy),     64'd0);
    chk("rst_frames", 64'(out_frames),   64'd0);
    greset = 1'b0;
    idle();

    // 4-bin frame 10,40,40,5: peak tie keeps bin 1
    set_len(10'd3);
    sample(32'd10);
    chk("t1_busy", 64'(out_busy), 64'd1);
    sample(32'd40);
    sample(32'd40);
    sample(32'd5);
    chk("t1_valid",  64'(out_valid),    64'd1);
    chk("t1_sum",    64'(out_sum),      64'd95);
    chk("t1_peak",   64'(out_peak),     64'd40);
    chk("t1_idx",    64'(out_peak_idx), 64'd1);
    chk("t1_frames", 64'(out_frames),   64'd1);
    chk("t1_idle",   64'(out_busy),     64'd0);
    idle();
    chk("t1_pulse",  64'(out_valid),    64'd0);
    chk("t1_hold",   64'(out_sum),      64'd95);

    // 1-bin frames back to back
    set_len(10'd0);
    sample(32'd7);
    chk("t2a_valid", 64'(out_valid),    64'd1);
    chk("t2a_sum",   64'(out_sum),      64'd7);
    chk("t2a_idx",   64'(out_peak_idx), 64'd0);
    chk("t2a_busy",  64'(out_busy),     64'd0);
    sample(32'd9);
    chk("t2b_valid", 64'(out_valid),    64'd1);
    chk("t2b_sum",   64'(out_sum),      64'd9);
    chk("t2b_idx",   64'(out_peak_idx), 64'd0);
    chk("t2b_frames", 64'(out_frames),  64'd3);
    idle();

    // 3-bin frame with gaps; length write mid-frame applies to the next frame
    set_len(10'd2);
    sample(32'd1);
    idle();
    idle();
    idle();
    chk("t3_gap_valid", 64'(out_valid), 64'd0);
    chk("t3_gap_busy",  64'(out_busy),  64'd1);
    sample(32'd2);
    set_len(10'd0);
    chk("t3_wr_valid", 64'(out_valid), 64'd0);
    sample(32'd3);
    chk("t3_valid",  64'(out_valid),    64'd1);
    chk("t3_sum",    64'(out_sum),      64'd6);
    chk("t3_peak",   64'(out_peak),     64'd3);
    chk("t3_idx",    64'(out_peak_idx), 64'd2);
    chk("t3_frames", 64'(out_frames),   64'd4);
    sample(32'd8);
    chk("t3n_valid", 64'(out_valid),    64'd1);
    chk("t3n_sum",   64'(out_sum),      64'd8);
    chk("t3n_frames", 64'(out_frames),  64'd5);
    idle();

    // abort mid-frame with a coincident sample
    set_len(10'd3);
    sample(32'd1);
    sample(32'd2);
    drive(1'b1, 32'd100, 1'b0, '0, 1'b1);
    chk("t4_clr_valid", 64'(out_valid),  64'd0);
    chk("t4_clr_busy",  64'(out_busy),   64'd0);
    chk("t4_clr_sum",   64'(out_sum),    64'd8);
    chk("t4_clr_frm",   64'(out_frames), 64'd5);
    sample(32'd1);
    sample(32'd1);
    sample(32'd1);
    chk("t4_mid_valid", 64'(out_valid),  64'd0);
    sample(32'd1);
    chk("t4_valid",  64'(out_valid),    64'd1);
    chk("t4_sum",    64'(out_sum),      64'd4);
    chk("t4_peak",   64'(out_peak),     64'd1);
    chk("t4_idx",    64'(out_peak_idx), 64'd0);
    chk("t4_frames", 64'(out_frames),   64'd6);
    idle();

    // four full-scale samples: 33-bit accumulator saturates, 42-bit does not
    for (int i = 0; i < 4; i++) sample(32'hFFFF_FFFF);
    chk("t5_s_valid", 64'(s_valid),      64'd1);
    chk("t5_s_sum",   64'(s_sum),        64'h1_FFFF_FFFF);
    chk("t5_s_peak",  64'(s_peak),       64'hFFFF_FFFF);
    chk("t5_s_idx",   64'(s_peak_idx),   64'd0);
    chk("t5_sum",     64'(out_sum),      64'h3_FFFF_FFFC);
    chk("t5_idx",     64'(out_peak_idx), 64'd0);
    chk("t5_frames",  64'(out_frames),   64'd7);
    idle();

    // asynchronous reset between edges, mid-frame
    sample(32'd5);
    sample(32'd6);
    #2 greset = 1'b1;
    #1;
    chk("t6_sum",    64'(out_sum),    64'd0);
    chk("t6_peak",   64'(out_peak),   64'd0);
    chk("t6_busy",   64'(out_busy),   64'd0);
    chk("t6_valid",  64'(out_valid),  64'd0);
    chk("t6_frames", 64'(out_frames), 64'd0);
    chk("t6_s_sum",  64'(s_sum),      64'd0);
    @(negedge gclk);
    greset = 1'b0;
    set_len(10'd3);
    sample(32'd2);
    sample(32'd3);
    sample(32'd4);
    sample(32'd5);
    chk("t6n_valid",  64'(out_valid),    64'd1);
    chk("t6n_sum",    64'(out_sum),      64'd14);
    chk("t6n_peak",   64'(out_peak),     64'd5);
    chk("t6n_idx",    64'(out_peak_idx), 64'd3);
    chk("t6n_frames", 64'(out_frames),   64'd1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
